// File: rtl/ps2_kbd_cmd_seq.sv
// Command sequencer for the PS2kbd register port: arbitrates two requesters, sends
// command/argument bytes, waits for ACK/RESEND with retries and per-phase timeouts.
module ps2_kbd_cmd_seq #(
    parameter int unsigned pClkFreq   = 50000000,
    parameter logic [31:0] KBD_ADDR   = 32'hFDFF8000,
    parameter int unsigned pTimeoutMs = 20,
    parameter int unsigned pMaxRetry  = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_i,
    input  logic [7:0]  cmd0_i,
    input  logic [7:0]  arg0_i,
    input  logic        narg0_i,
    input  logic [7:0]  cmd1_i,
    input  logic [7:0]  arg1_i,
    input  logic        narg1_i,
    output logic [1:0]  done_o,
    output logic [1:0]  err_o,
    output logic        busy_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic        m_ack_i,
    input  logic [31:0] m_dat_i
);

    localparam logic [31:0] TC = 32'(pClkFreq / 1000 * pTimeoutMs);
    localparam int RW = (pMaxRetry < 1) ? 1 : $clog2(pMaxRetry + 1);
    localparam logic [RW-1:0] MAXR = RW'(pMaxRetry);

    typedef enum logic [3:0] {
        S_IDLE, S_WR, S_PTC, S_PRX, S_RD, S_CLR, S_EVAL, S_ABT, S_ERR, S_FIN
    } state_t;

    state_t        r_state, w_state;
    logic          r_grant, w_grant, r_last, w_last;
    logic [7:0]    r_cmd, w_cmd, r_arg, w_arg, r_byte, w_byte, r_rx, w_rx;
    logic          r_narg, w_narg, r_is_arg, w_is_arg;
    logic [RW-1:0] r_retry, w_retry;
    logic [31:0]   r_timer, w_timer;
    logic          r_busy, w_busy;
    logic [1:0]    r_done, w_done, r_err, w_err;
    logic          r_cyc, w_cyc, r_we, w_we_n;
    logic [3:0]    r_sel, w_sel;
    logic [31:0]   r_adr, w_adr, r_dat, w_dat;
    logic          w_go, w_we, w_off;
    logic [7:0]    w_wdat;
    logic          w_unused;

    assign w_unused = ^m_dat_i[31:8];

    // Next-state and datapath decisions; bus accesses only start while the bus is idle
    always_comb begin
        w_state  = r_state;
        w_grant  = r_grant;
        w_last   = r_last;
        w_cmd    = r_cmd;
        w_arg    = r_arg;
        w_narg   = r_narg;
        w_byte   = r_byte;
        w_is_arg = r_is_arg;
        w_rx     = r_rx;
        w_retry  = r_retry;
        w_timer  = r_timer;
        w_busy   = r_busy;
        w_done   = 2'b00;
        w_err    = 2'b00;
        w_go     = 1'b0;
        w_we     = 1'b0;
        w_off    = 1'b0;
        w_wdat   = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (|req_i) begin
                    w_grant  = (req_i == 2'b11) ? ~r_last : req_i[1];
                    w_last   = w_grant;
                    w_cmd    = w_grant ? cmd1_i : cmd0_i;
                    w_arg    = w_grant ? arg1_i : arg0_i;
                    w_narg   = w_grant ? narg1_i : narg0_i;
                    w_byte   = w_cmd;
                    w_is_arg = 1'b0;
                    w_retry  = '0;
                    w_busy   = 1'b1;
                    w_state  = S_WR;
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_WR: begin
                if (!r_cyc) begin
                    w_go = 1'b1; w_we = 1'b1; w_off = 1'b0; w_wdat = r_byte;
                end else if (m_ack_i) begin
                    w_timer = 32'd0;
                    w_state = S_PTC;
                end else begin
                    w_state = S_WR;
                end
            end
            S_PTC, S_PRX: begin
                // Timer runs through the polling reads and saturates at terminal count
                if (r_timer < TC) begin
                    w_timer = r_timer + 32'd1;
                end else begin
                    w_timer = r_timer;
                end
                if (!r_cyc) begin
                    if (r_timer >= TC) begin
                        w_state = S_ABT;
                    end else begin
                        w_go = 1'b1; w_we = 1'b0; w_off = 1'b1;
                    end
                end else if (m_ack_i && (r_state == S_PTC) && m_dat_i[6]) begin
                    w_timer = 32'd0;
                    w_state = S_PRX;
                end else if (m_ack_i && (r_state == S_PRX) && m_dat_i[7]) begin
                    w_state = S_RD;
                end else begin
                    w_state = r_state;
                end
            end
            S_RD: begin
                if (!r_cyc) begin
                    w_go = 1'b1; w_we = 1'b0; w_off = 1'b0;
                end else if (m_ack_i) begin
                    w_rx    = m_dat_i[7:0];
                    w_state = S_CLR;
                end else begin
                    w_state = S_RD;
                end
            end
            S_CLR: begin
                if (!r_cyc) begin
                    w_go = 1'b1; w_we = 1'b1; w_off = 1'b1; w_wdat = 8'h00;
                end else if (m_ack_i) begin
                    w_state = S_EVAL;
                end else begin
                    w_state = S_CLR;
                end
            end
            S_EVAL: begin
                if (r_rx == 8'hFA) begin
                    if (!r_is_arg && r_narg) begin
                        w_byte   = r_arg;
                        w_is_arg = 1'b1;
                        w_retry  = '0;
                        w_state  = S_WR;
                    end else begin
                        w_done  = r_grant ? 2'b10 : 2'b01;
                        w_busy  = 1'b0;
                        w_state = S_FIN;
                    end
                end else if (r_rx == 8'hFE) begin
                    if (r_retry < MAXR) begin
                        w_retry = r_retry + RW'(1);
                        w_state = S_WR;
                    end else begin
                        w_state = S_ABT;
                    end
                end else begin
                    w_state = S_ABT;
                end
            end
            S_ABT: begin
                if (!r_cyc) begin
                    w_go = 1'b1; w_we = 1'b1; w_off = 1'b1; w_wdat = 8'hFF;
                end else if (m_ack_i) begin
                    w_err   = r_grant ? 2'b10 : 2'b01;
                    w_busy  = 1'b0;
                    w_state = S_ERR;
                end else begin
                    w_state = S_ABT;
                end
            end
            S_ERR:   w_state = S_IDLE;
            S_FIN:   w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
    end

    // Bus signals: launch together, hold until ack, drop all the cycle after ack
    always_comb begin
        w_cyc  = r_cyc;
        w_we_n = r_we;
        w_adr  = r_adr;
        w_sel  = r_sel;
        w_dat  = r_dat;
        if (w_go) begin
            w_cyc  = 1'b1;
            w_we_n = w_we;
            w_adr  = KBD_ADDR + 32'(w_off);
            w_sel  = 4'b0001 << w_adr[1:0];
            w_dat  = w_we ? {4{w_wdat}} : 32'h0000_0000;
        end else if (r_cyc && m_ack_i) begin
            w_cyc  = 1'b0;
            w_we_n = 1'b0;
            w_adr  = 32'h0000_0000;
            w_sel  = 4'b0000;
            w_dat  = 32'h0000_0000;
        end else begin
            w_cyc = r_cyc;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_grant  <= 1'b0;
            r_last   <= 1'b1;
            r_cmd    <= 8'h00;
            r_arg    <= 8'h00;
            r_narg   <= 1'b0;
            r_byte   <= 8'h00;
            r_is_arg <= 1'b0;
            r_rx     <= 8'h00;
            r_retry  <= '0;
            r_timer  <= 32'd0;
            r_busy   <= 1'b0;
            r_done   <= 2'b00;
            r_err    <= 2'b00;
            r_cyc    <= 1'b0;
            r_we     <= 1'b0;
            r_sel    <= 4'b0000;
            r_adr    <= 32'h0000_0000;
            r_dat    <= 32'h0000_0000;
        end else begin
            r_state  <= w_state;
            r_grant  <= w_grant;
            r_last   <= w_last;
            r_cmd    <= w_cmd;
            r_arg    <= w_arg;
            r_narg   <= w_narg;
            r_byte   <= w_byte;
            r_is_arg <= w_is_arg;
            r_rx     <= w_rx;
            r_retry  <= w_retry;
            r_timer  <= w_timer;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_err    <= w_err;
            r_cyc    <= w_cyc;
            r_we     <= w_we_n;
            r_sel    <= w_sel;
            r_adr    <= w_adr;
            r_dat    <= w_dat;
        end
    end

    assign done_o  = r_done;
    assign err_o   = r_err;
    assign busy_o  = r_busy;
    assign m_cyc_o = r_cyc;
    assign m_stb_o = r_cyc;
    assign m_we_o  = r_we;
    assign m_sel_o = r_sel;
    assign m_adr_o = r_adr;
    assign m_dat_o = r_dat;

endmodule

// File: tb/tb_ps2_kbd_cmd_seq.sv
// Bench for ps2_kbd_cmd_seq: behavioural PS2kbd slave, vector table of request
// scenarios, plus directed timeout, arbitration and reset-mid-transfer sequences.
module tb_ps2_kbd_cmd_seq;

    localparam logic [31:0] KBD = 32'hFDFF8000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [7:0]  cmd0 = 8'h00, arg0 = 8'h00, cmd1 = 8'h00, arg1 = 8'h00;
    logic        narg0 = 1'b0, narg1 = 1'b0;
    logic [1:0]  done_o, err_o;
    logic        busy_o, m_cyc_o, m_stb_o, m_we_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_adr_o, m_dat_o;
    logic        m_ack_i = 1'b0;
    logic [31:0] m_dat_i = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;

    // keyboard model state
    logic       tc_f = 1'b0, rx_f = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] replies[$];
    logic [7:0] txlog[$];
    int         clr_cnt = 0, abt_cnt = 0, proto_err = 0;
    bit         no_tc = 1'b0, no_rx = 1'b0;

    ps2_kbd_cmd_seq #(
        .pClkFreq(50000000), .KBD_ADDR(KBD), .pTimeoutMs(1), .pMaxRetry(3)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req),
        .cmd0_i(cmd0), .arg0_i(arg0), .narg0_i(narg0),
        .cmd1_i(cmd1), .arg1_i(arg1), .narg1_i(narg1),
        .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_ack_i(m_ack_i), .m_dat_i(m_dat_i)
    );

    always #5 clk = ~clk;

    // Slave model and bus-protocol monitor, both on the falling edge
    always @(negedge clk) begin
        if (m_cyc_o === 1'b1) begin
            if (m_stb_o !== 1'b1) proto_err++;
            if (m_sel_o !== (4'b0001 << m_adr_o[1:0])) proto_err++;
            if (m_adr_o !== KBD && m_adr_o !== KBD + 32'd1) proto_err++;
            if (m_we_o && m_dat_o !== {4{m_dat_o[7:0]}}) proto_err++;
            if (m_ack_i) proto_err++;
        end else if (m_stb_o === 1'b1) begin
            proto_err++;
        end
        if (rst) begin
            m_ack_i = 1'b0; tc_f = 1'b0; rx_f = 1'b0;
        end else if (m_cyc_o !== 1'b1 || m_ack_i) begin
            m_ack_i = 1'b0;
        end else begin
            m_ack_i = 1'b1;
            if (m_we_o) begin
                if (m_adr_o[0] == 1'b0) begin
                    txlog.push_back(m_dat_o[7:0]);
                    if (!no_tc) tc_f = 1'b1;
                    if (!no_rx) begin
                        if (replies.size() > 0) rx_byte = replies.pop_front();
                        else rx_byte = 8'hFA;
                        rx_f = 1'b1;
                    end
                end else begin
                    if (m_dat_o[7:0] == 8'h00) clr_cnt++;
                    else if (m_dat_o[7:0] == 8'hFF) abt_cnt++;
                    tc_f = 1'b0; rx_f = 1'b0;
                end
            end else begin
                m_dat_i = m_adr_o[0] ? {24'h0, rx_f, tc_f, 6'h00} : {24'h0, rx_byte};
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_model();
        txlog.delete(); replies.delete();
        clr_cnt = 0; abt_cnt = 0;
    endtask

    // Raise a request, wait for its completion pulse, then check busy and pulse width
    task automatic do_req(input logic [1:0] r, input int budget,
                          output logic [1:0] d, output logic [1:0] e, output int cyc);
        bit got;
        got = 1'b0; d = 2'b00; e = 2'b00; cyc = 0;
        req = r;
        while (!got && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("busy_rise", busy_o, 1);
            if ((done_o | err_o) != 2'b00) got = 1'b1;
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL req_timeout: no done/err within %0d cycles", budget);
        end else begin
            d = done_o; e = err_o;
            check("busy_at_pulse", busy_o, 0);
        end
        req = 2'b00;
        @(negedge clk);
        check("pulse_width", {done_o, err_o}, 4'b0000);
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [7:0]  cmd;
        logic [7:0]  arg;
        logic        narg;
        logic [63:0] rep;
        int          nrep;
        logic [1:0]  exp_done;
        logic [1:0]  exp_err;
        int          exp_tx;
        logic [7:0]  exp_first;
        logic [7:0]  exp_last;
        int          exp_clr;
        int          exp_abt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [1:0] d, e;
        int         cyc;
        logic [1:0] exp_p;
        logic [7:0] exp_b;

        vecs[0] = '{2'b01, 8'hED, 8'h02, 1'b1, 64'h0000_0000_0000_FAFA, 2, 2'b01, 2'b00, 2, 8'hED, 8'h02, 2, 0};
        vecs[1] = '{2'b10, 8'hF3, 8'h00, 1'b0, 64'h0000_0000_00FA_FEFE, 3, 2'b10, 2'b00, 3, 8'hF3, 8'hF3, 3, 0};
        vecs[2] = '{2'b01, 8'hED, 8'h00, 1'b0, 64'h0000_0000_FEFE_FEFE, 4, 2'b00, 2'b01, 4, 8'hED, 8'hED, 4, 1};
        vecs[3] = '{2'b10, 8'hF4, 8'h00, 1'b0, 64'h0000_0000_0000_00AA, 1, 2'b00, 2'b10, 1, 8'hF4, 8'hF4, 1, 1};
        vecs[4] = '{2'b01, 8'hED, 8'h07, 1'b1, 64'h0000_0000_00FA_FEFA, 3, 2'b01, 2'b00, 3, 8'hED, 8'h07, 3, 0};
        vecs[5] = '{2'b10, 8'hF3, 8'h20, 1'b1, 64'h0000_0000_FAFE_FEFE, 4, 2'b10, 2'b00, 5, 8'hF3, 8'h20, 5, 0};
        vecs[6] = '{2'b01, 8'hED, 8'h03, 1'b1, 64'h0000_FAFE_FAFE_FEFE, 6, 2'b01, 2'b00, 6, 8'hED, 8'h03, 6, 0};

        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_cyc", {m_cyc_o, m_stb_o, m_we_o}, 3'b000);
        check("rst_pulses", {done_o, err_o}, 4'b0000);
        check("rst_adr", m_adr_o, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            clear_model();
            for (int k = 0; k < vecs[i].nrep; k++) replies.push_back(vecs[i].rep[k*8 +: 8]);
            if (vecs[i].req == 2'b01) begin
                cmd0 = vecs[i].cmd; arg0 = vecs[i].arg; narg0 = vecs[i].narg;
            end else begin
                cmd1 = vecs[i].cmd; arg1 = vecs[i].arg; narg1 = vecs[i].narg;
            end
            do_req(vecs[i].req, 2000, d, e, cyc);
            check($sformatf("v%0d_done", i), d, vecs[i].exp_done);
            check($sformatf("v%0d_err", i), e, vecs[i].exp_err);
            check($sformatf("v%0d_ntx", i), txlog.size(), vecs[i].exp_tx);
            if (txlog.size() > 0) begin
                check($sformatf("v%0d_first_tx", i), txlog[0], vecs[i].exp_first);
                check($sformatf("v%0d_last_tx", i), txlog[txlog.size()-1], vecs[i].exp_last);
            end
            check($sformatf("v%0d_clr", i), clr_cnt, vecs[i].exp_clr);
            check($sformatf("v%0d_abt", i), abt_cnt, vecs[i].exp_abt);
            repeat (2) @(negedge clk);
        end

        // transmit-complete never arrives: abort after the 1 ms phase timeout
        clear_model();
        no_tc = 1'b1;
        cmd0 = 8'hED; narg0 = 1'b0;
        do_req(2'b01, 60000, d, e, cyc);
        check("t4_err", e, 2'b01);
        check("t4_done", d, 2'b00);
        check("t4_window", (cyc >= 50000 && cyc <= 50020), 1'b1);
        check("t4_abt", abt_cnt, 1);
        check("t4_ntx", txlog.size(), 1);
        no_tc = 1'b0;
        repeat (2) @(negedge clk);

        // reset while polling for the reply byte
        clear_model();
        no_rx = 1'b1;
        req = 2'b01;
        repeat (20) @(negedge clk);
        cyc = 0;
        while (m_cyc_o !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_busy_before", {busy_o, m_cyc_o}, 2'b11);
        #2 rst = 1'b1;
        #1;
        check("t6_cyc_drop", {m_cyc_o, m_stb_o}, 2'b00);
        check("t6_busy_drop", busy_o, 0);
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("t6_no_abt", abt_cnt, 0);
        rst = 1'b0;
        no_rx = 1'b0;
        @(negedge clk);

        // both requesters held: round-robin starting with requester 0 after reset
        clear_model();
        cmd0 = 8'hA0; narg0 = 1'b0;
        cmd1 = 8'hB1; narg1 = 1'b0;
        req = 2'b11;
        for (int p = 0; p < 4; p++) begin
            cyc = 0;
            d = 2'b00;
            while ((done_o | err_o) == 2'b00 && cyc < 2000) begin
                @(negedge clk);
                cyc++;
            end
            d = done_o;
            if (p == 3) req = 2'b00;
            exp_p = (p % 2 == 0) ? 2'b01 : 2'b10;
            check($sformatf("t5_grant%0d", p), d, exp_p);
            @(negedge clk);
        end
        check("t5_ntx", txlog.size(), 4);
        for (int p = 0; p < 4; p++) begin
            if (p < txlog.size()) begin
                exp_b = (p % 2 == 0) ? 8'hA0 : 8'hB1;
                check($sformatf("t5_tx%0d", p), txlog[p], exp_b);
            end
        end
        check("t5_abt", abt_cnt, 0);
        repeat (3) @(negedge clk);
        check("idle_after", {busy_o, m_cyc_o}, 2'b00);
        check("bus_protocol", proto_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
